ext_cache_bridge: RTL and testbench

Parametrised multi-channel successor to the single-channel external cache wrapper. It accepts NCH Kôika external-function channels, each a packed `arg`/`out` bus with get/put handshakes. Put requests are buffered per channel and merged round-robin onto one downstream cache port. In-order downstream responses are steered back to the issuing channel through per-channel response FIFOs, with credit-based flow control. It sits between the Kôika-generated core and a single cache model shared by several cores or ports.

---
 rtl/ext_cache_bridge_pkg.sv | 28 ++
 rtl/ext_cache_bridge_fifo.sv | 60 ++++++
 rtl/ext_cache_bridge.sv | 177 +++++++++++++++++
 tb/tb_ext_cache_bridge.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_cache_bridge_pkg.sv
// ext_cache_bridge shared types and helpers.
// Channel ID width and arg/out slice offsets.
package ext_cache_bridge_pkg;

   localparam int unsigned DEF_NCH  = 2;
   localparam int unsigned DEF_ID_W = (DEF_NCH > 1) ? $clog2(DEF_NCH) : 1;

   typedef logic [DEF_ID_W-1:0] chan_id_t;

   function automatic int unsigned id_width(input int unsigned nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

   function automatic int unsigned arg_base(
      input int unsigned c,
      input int unsigned req_w
   );
      return c * (req_w + 2);
   endfunction

   function automatic int unsigned out_base(
      input int unsigned c,
      input int unsigned resp_w
   );
      return c * (resp_w + 2);
   endfunction

endpackage

// File: rtl/ext_cache_bridge_fifo.sv
// bridge_fifo: synchronous FIFO, async active-high reset.
// Push and pop in one cycle keep occupancy and order.
module bridge_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // pointer and occupancy bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // storage array, contents need no reset
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/ext_cache_bridge.sv
// ext_cache_bridge: NCH Koika channels merged round-robin
// onto one cache port, responses steered back by ID FIFO.
module ext_cache_bridge
   import ext_cache_bridge_pkg::*;
#(
   parameter int unsigned NCH     = 2,
   parameter int unsigned REQ_W   = 70,
   parameter int unsigned RESP_W  = 52,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned MAX_OUT = 8
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [NCH*(REQ_W+2)-1:0]   arg,
   output logic [NCH*(RESP_W+2)-1:0]  out,
   output logic                       mem_put_valid,
   input  logic                       mem_put_ready,
   output logic [REQ_W-1:0]           mem_put_request,
   output logic                       mem_get_valid,
   input  logic                       mem_get_ready,
   input  logic [RESP_W-1:0]          mem_get_response
);

   localparam int unsigned IDW = id_width(NCH);
   localparam int unsigned CW  = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);

   logic [NCH-1:0]    put_valid;
   logic [NCH-1:0]    get_valid;
   logic [NCH-1:0]    put_ready;
   logic [NCH-1:0]    get_ready;
   logic [NCH-1:0]    put_fire;
   logic [NCH-1:0]    get_fire;
   logic [REQ_W-1:0]  put_req [NCH];
   logic [REQ_W-1:0]  slot [NCH];
   logic [NCH-1:0]    slot_full;
   logic [CW-1:0]     cnt [NCH];
   logic [RESP_W-1:0] resp_head [NCH];
   logic [NCH-1:0]    resp_empty;
   logic [NCH-1:0]    resp_full;
   logic [NCH-1:0]    resp_push;
   logic [IDW-1:0]    last_grant;
   logic [IDW-1:0]    rr_pick;
   logic [IDW-1:0]    grant;
   logic [IDW-1:0]    hold_id;
   logic              hold_q;
   logic [IDW-1:0]    id_head;
   logic              id_full;
   logic              id_empty;
   logic              mem_put_fire;
   logic              mem_get_fire;

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      localparam int unsigned AB = arg_base(c, REQ_W);
      localparam int unsigned OB = out_base(c, RESP_W);

      assign put_req[c]   = arg[AB +: REQ_W];
      assign put_valid[c] = arg[AB + REQ_W];
      assign get_valid[c] = arg[AB + REQ_W + 1];

      assign put_ready[c] = !RST && !slot_full[c]
                         && (cnt[c] < CRED_MAX);
      assign get_ready[c] = !RST && !resp_empty[c];
      assign put_fire[c]  = put_valid[c] && put_ready[c];
      assign get_fire[c]  = get_valid[c] && get_ready[c];
      assign resp_push[c] = mem_get_fire
                         && (id_head == IDW'(c));

      assign out[OB +: RESP_W]    = RST ? '0 : resp_head[c];
      assign out[OB + RESP_W]     = put_ready[c];
      assign out[OB + RESP_W + 1] = get_ready[c];

      bridge_fifo #(
         .WIDTH (RESP_W),
         .DEPTH (DEPTH)
      ) u_resp (
         .clk   (CLK),
         .rst   (RST),
         .push  (resp_push[c]),
         .din   (mem_get_response),
         .pop   (get_fire[c]),
         .dout  (resp_head[c]),
         .full  (resp_full[c]),
         .empty (resp_empty[c])
      );
   end

   // request slots: fill on channel put, drain on grant
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < NCH; i++) begin
            slot_full[i] <= 1'b0;
            slot[i]      <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (put_fire[i]) begin
               slot_full[i] <= 1'b1;
               slot[i]      <= put_req[i];
            end else if (mem_put_fire
                      && grant == IDW'(i)) begin
               slot_full[i] <= 1'b0;
            end
         end
      end
   end

   // credits cover slot, in-flight and response FIFO
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < NCH; i++)
            cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            unique case ({put_fire[i], get_fire[i]})
               2'b10:   cnt[i] <= cnt[i] + CW'(1);
               2'b01:   cnt[i] <= cnt[i] - CW'(1);
               default: cnt[i] <= cnt[i];
            endcase
         end
      end
   end

   // round-robin search starting after last_grant
   always_comb begin
      logic        found;
      int unsigned k;
      found   = 1'b0;
      k       = 0;
      rr_pick = last_grant;
      for (int i = 1; i <= NCH; i++) begin
         k = (int'(last_grant) + i) % NCH;
         if (!found && slot_full[k]) begin
            rr_pick = IDW'(k);
            found   = 1'b1;
         end
      end
   end

   assign grant           = hold_q ? hold_id : rr_pick;
   assign mem_put_valid   = !RST && (|slot_full) && !id_full;
   assign mem_put_request = RST ? '0 : slot[grant];
   assign mem_put_fire    = mem_put_valid && mem_put_ready;
   assign mem_get_valid   = !RST && !id_empty
                         && !resp_full[id_head];
   assign mem_get_fire    = mem_get_valid && mem_get_ready;

   // freeze a stalled grant until the cache accepts it
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         last_grant <= IDW'(NCH - 1);
         hold_q     <= 1'b0;
         hold_id    <= '0;
      end else if (mem_put_fire) begin
         last_grant <= grant;
         hold_q     <= 1'b0;
      end else if (mem_put_valid) begin
         hold_q     <= 1'b1;
         hold_id    <= grant;
      end
   end

   bridge_fifo #(
      .WIDTH (IDW),
      .DEPTH (MAX_OUT)
   ) u_id (
      .clk   (CLK),
      .rst   (RST),
      .push  (mem_put_fire),
      .din   (grant),
      .pop   (mem_get_fire),
      .dout  (id_head),
      .full  (id_full),
      .empty (id_empty)
   );

endmodule

// File: tb/tb_ext_cache_bridge.sv
// Directed bench for ext_cache_bridge with an in-order
// cache model answering req ^ 0x2F.
module tb_ext_cache_bridge;

   localparam int NCH     = 3;
   localparam int REQ_W   = 70;
   localparam int RESP_W  = 52;
   localparam int DEPTH   = 4;
   localparam int MAX_OUT = 8;
   localparam int AS      = REQ_W + 2;
   localparam int OS      = RESP_W + 2;

   logic                  CLK = 1'b0;
   logic                  RST;
   logic [NCH*AS-1:0]     arg;
   logic [NCH*OS-1:0]     out;
   logic                  mem_put_valid;
   logic                  mem_put_ready;
   logic [REQ_W-1:0]      mem_put_request;
   logic                  mem_get_valid;
   wire                   mem_get_ready;
   wire  [RESP_W-1:0]     mem_get_response;

   logic                  get_en;
   logic                  q_ne;
   logic [RESP_W-1:0]     q_head;
   logic [RESP_W-1:0]     cq [$];
   int                    put_fires;
   int                    get_fires;
   int                    tests;
   int                    fails;

   assign mem_get_ready    = get_en && q_ne;
   assign mem_get_response = q_head;

   ext_cache_bridge #(
      .NCH     (NCH),
      .REQ_W   (REQ_W),
      .RESP_W  (RESP_W),
      .DEPTH   (DEPTH),
      .MAX_OUT (MAX_OUT)
   ) dut (
      .CLK              (CLK),
      .RST              (RST),
      .arg              (arg),
      .out              (out),
      .mem_put_valid    (mem_put_valid),
      .mem_put_ready    (mem_put_ready),
      .mem_put_request  (mem_put_request),
      .mem_get_valid    (mem_get_valid),
      .mem_get_ready    (mem_get_ready),
      .mem_get_response (mem_get_response)
   );

   always #5 CLK = ~CLK;

   // cache model: sample fires at the edge, update 1ns later
   always @(posedge CLK) begin : cache
      logic             pf;
      logic             gf;
      logic [REQ_W-1:0] rq;
      pf = mem_put_valid && mem_put_ready;
      gf = mem_get_valid && mem_get_ready;
      rq = mem_put_request;
      #1;
      if (RST) begin
         cq.delete();
      end else begin
         if (gf) begin
            void'(cq.pop_front());
            get_fires++;
         end
         if (pf) begin
            cq.push_back(rq[RESP_W-1:0] ^ RESP_W'('h2F));
            put_fires++;
         end
      end
      q_ne   = (cq.size() > 0);
      q_head = (cq.size() > 0) ? cq[0] : '0;
   end

   // response FIFO overflow monitor
   always @(posedge CLK) begin
      if (!RST) begin
         for (int c = 0; c < NCH; c++) begin
            if (dut.resp_push[c] && dut.resp_full[c]
                && !dut.get_fire[c]) begin
               fails++;
               $display("FAIL resp_overflow ch%0d: push while full, required no push", c);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_put(input int c, input logic v,
                          input logic [REQ_W-1:0] r);
      arg[c*AS +: REQ_W] = r;
      arg[c*AS + REQ_W]  = v;
   endtask

   task automatic set_get(input int c, input logic v);
      arg[c*AS + REQ_W + 1] = v;
   endtask

   function automatic logic pr(input int c);
      return out[c*OS + RESP_W];
   endfunction

   function automatic logic gr(input int c);
      return out[c*OS + RESP_W + 1];
   endfunction

   function automatic logic [RESP_W-1:0] gresp(input int c);
      return out[c*OS +: RESP_W];
   endfunction

   task automatic test_reset();
      get_en        = 1'b0;
      mem_put_ready = 1'b1;
      @(negedge CLK);
      set_put(0, 1'b1, 70'h11);
      set_put(1, 1'b1, 70'h22);
      @(negedge CLK);
      set_put(0, 1'b0, '0);
      set_put(1, 1'b0, '0);
      repeat (2) @(negedge CLK);
      tests++;
      if (mem_get_valid !== 1'b1) begin
         fails++;
         $display("FAIL rst_pre_outstanding: got %b want 1", mem_get_valid);
      end
      #2 RST = 1'b1;
      #1;
      for (int c = 0; c < 2; c++) begin
         tests++;
         if (pr(c) !== 1'b0 || gr(c) !== 1'b0) begin
            fails++;
            $display("FAIL rst_ready_ch%0d: put_ready=%b get_ready=%b want 0 0", c, pr(c), gr(c));
         end
      end
      tests++;
      if (mem_put_valid !== 1'b0 || mem_get_valid !== 1'b0) begin
         fails++;
         $display("FAIL rst_mem_valid: put=%b get=%b want 0 0", mem_put_valid, mem_get_valid);
      end
      tests++;
      if (mem_put_request !== '0 || out !== '0) begin
         fails++;
         $display("FAIL rst_data: req=%h out=%h want 0", mem_put_request, out);
      end
      @(negedge CLK);
      RST = 1'b0;
      #1;
      for (int c = 0; c < 2; c++) begin
         tests++;
         if (pr(c) !== 1'b1 || gr(c) !== 1'b0 || dut.cnt[c] !== 3'd0) begin
            fails++;
            $display("FAIL rst_release_ch%0d: put_ready=%b get_ready=%b cnt=%0d want 1 0 0", c, pr(c), gr(c), dut.cnt[c]);
         end
      end
      get_en = 1'b1;
      repeat (3) @(negedge CLK);
      tests++;
      if (mem_get_valid !== 1'b0 || gr(0) !== 1'b0 || gr(1) !== 1'b0) begin
         fails++;
         $display("FAIL rst_no_stale: mem_get_valid=%b gr0=%b gr1=%b want 0 0 0", mem_get_valid, gr(0), gr(1));
      end
   endtask

   task automatic test_single();
      get_en        = 1'b1;
      mem_put_ready = 1'b1;
      @(negedge CLK);
      set_put(1, 1'b1, 70'h2A);
      @(negedge CLK);
      set_put(1, 1'b0, '0);
      tests++;
      if (mem_put_valid !== 1'b1 || mem_put_request !== 70'h2A) begin
         fails++;
         $display("FAIL single_put: valid=%b req=%h want 1 2a", mem_put_valid, mem_put_request);
      end
      @(negedge CLK);
      tests++;
      if (gr(1) !== 1'b0 || mem_get_valid !== 1'b1) begin
         fails++;
         $display("FAIL single_inflight: gr1=%b mem_get_valid=%b want 0 1", gr(1), mem_get_valid);
      end
      @(negedge CLK);
      tests++;
      if (gr(1) !== 1'b1 || gresp(1) !== 52'h5 || gr(0) !== 1'b0) begin
         fails++;
         $display("FAIL single_resp: gr1=%b resp=%h gr0=%b want 1 5 0", gr(1), gresp(1), gr(0));
      end
      set_get(1, 1'b1);
      @(negedge CLK);
      set_get(1, 1'b0);
      tests++;
      if (gr(1) !== 1'b0 || dut.cnt[1] !== 3'd0) begin
         fails++;
         $display("FAIL single_pop: gr1=%b cnt=%0d want 0 0", gr(1), dut.cnt[1]);
      end
   endtask

   task automatic test_contention();
      @(negedge CLK);
      set_put(0, 1'b1, 70'h111);
      set_put(1, 1'b1, 70'h222);
      @(negedge CLK);
      set_put(0, 1'b0, '0);
      set_put(1, 1'b0, '0);
      tests++;
      if (mem_put_valid !== 1'b1 || mem_put_request !== 70'h111) begin
         fails++;
         $display("FAIL cont_first: valid=%b req=%h want 1 111", mem_put_valid, mem_put_request);
      end
      @(negedge CLK);
      tests++;
      if (mem_put_valid !== 1'b1 || mem_put_request !== 70'h222) begin
         fails++;
         $display("FAIL cont_second: valid=%b req=%h want 1 222", mem_put_valid, mem_put_request);
      end
      @(negedge CLK);
      tests++;
      if (gr(0) !== 1'b1 || gresp(0) !== 52'h13E || gr(1) !== 1'b0) begin
         fails++;
         $display("FAIL cont_r0: gr0=%b resp0=%h gr1=%b want 1 13e 0", gr(0), gresp(0), gr(1));
      end
      @(negedge CLK);
      tests++;
      if (gr(1) !== 1'b1 || gresp(1) !== 52'h20D) begin
         fails++;
         $display("FAIL cont_r1: gr1=%b resp1=%h want 1 20d", gr(1), gresp(1));
      end
      set_get(0, 1'b1);
      set_get(1, 1'b1);
      @(negedge CLK);
      set_get(0, 1'b0);
      set_get(1, 1'b0);
      tests++;
      if (gr(0) !== 1'b0 || gr(1) !== 1'b0) begin
         fails++;
         $display("FAIL cont_pop: gr0=%b gr1=%b want 0 0", gr(0), gr(1));
      end
   endtask

   task automatic test_credit();
      for (int k = 0; k < 4; k++) begin
         int w;
         w = 0;
         while (!pr(0) && w < 10) begin
            @(negedge CLK);
            w++;
         end
         tests++;
         if (w >= 10) begin
            fails++;
            $display("FAIL credit_wait%0d: put_ready=%b want 1", k, pr(0));
         end
         set_put(0, 1'b1, 70'h300 + 70'(k));
         @(negedge CLK);
         set_put(0, 1'b0, '0);
      end
      tests++;
      if (pr(0) !== 1'b0) begin
         fails++;
         $display("FAIL credit_after4: put_ready=%b want 0", pr(0));
      end
      repeat (6) @(negedge CLK);
      tests++;
      if (pr(0) !== 1'b0 || dut.cnt[0] !== 3'd4 || gr(0) !== 1'b1 || gresp(0) !== 52'h32F) begin
         fails++;
         $display("FAIL credit_full: pr=%b cnt=%0d gr=%b resp=%h want 0 4 1 32f", pr(0), dut.cnt[0], gr(0), gresp(0));
      end
      set_get(0, 1'b1);
      @(negedge CLK);
      set_get(0, 1'b0);
      tests++;
      if (pr(0) !== 1'b1) begin
         fails++;
         $display("FAIL credit_restore: put_ready=%b want 1", pr(0));
      end
      for (int k = 1; k < 4; k++) begin
         tests++;
         if (gr(0) !== 1'b1 || gresp(0) !== 52'h32F - 52'(k)) begin
            fails++;
            $display("FAIL credit_drain%0d: gr=%b resp=%h want 1 %h", k, gr(0), gresp(0), 52'h32F - 52'(k));
         end
         set_get(0, 1'b1);
         @(negedge CLK);
         set_get(0, 1'b0);
      end
      tests++;
      if (gr(0) !== 1'b0 || dut.cnt[0] !== 3'd0) begin
         fails++;
         $display("FAIL credit_empty: gr=%b cnt=%0d want 0 0", gr(0), dut.cnt[0]);
      end
   endtask

   task automatic test_inflight();
      int base;
      int gbase;
      int n0;
      int n1;
      int g [3];
      logic [RESP_W-1:0] r2;
      get_en        = 1'b0;
      mem_put_ready = 1'b1;
      base = put_fires;
      n0 = 0;
      n1 = 0;
      r2 = '0;
      repeat (30) begin
         set_put(0, pr(0), 70'h400 + 70'(n0));
         if (pr(0)) n0++;
         set_put(1, pr(1), 70'h500 + 70'(n1));
         if (pr(1)) n1++;
         @(negedge CLK);
      end
      set_put(0, 1'b0, '0);
      set_put(1, 1'b0, '0);
      tests++;
      if (put_fires - base != 8 || mem_put_valid !== 1'b0) begin
         fails++;
         $display("FAIL inflight_cap: fires=%0d valid=%b want 8 0", put_fires - base, mem_put_valid);
      end
      tests++;
      if (pr(2) !== 1'b1) begin
         fails++;
         $display("FAIL inflight_ch2_ready: %b want 1", pr(2));
      end
      set_put(2, 1'b1, 70'h5AA);
      @(negedge CLK);
      set_put(2, 1'b0, '0);
      @(negedge CLK);
      tests++;
      if (mem_put_valid !== 1'b0 || put_fires - base != 8) begin
         fails++;
         $display("FAIL inflight_blocked: valid=%b fires=%0d want 0 8", mem_put_valid, put_fires - base);
      end
      gbase  = get_fires;
      get_en = 1'b1;
      @(negedge CLK);
      get_en = 1'b0;
      tests++;
      if (mem_put_valid !== 1'b1 || get_fires - gbase != 1) begin
         fails++;
         $display("FAIL inflight_reenable: valid=%b gets=%0d want 1 1", mem_put_valid, get_fires - gbase);
      end
      get_en = 1'b1;
      for (int c = 0; c < 3; c++) g[c] = 0;
      repeat (30) begin
         for (int c = 0; c < 3; c++) begin
            set_get(c, gr(c));
            if (gr(c)) g[c]++;
         end
         if (gr(2)) r2 = gresp(2);
         @(negedge CLK);
      end
      for (int c = 0; c < 3; c++) set_get(c, 1'b0);
      tests++;
      if (g[0] != 4 || g[1] != 4 || g[2] != 1 || r2 !== 52'h585) begin
         fails++;
         $display("FAIL inflight_drain: gets=%0d/%0d/%0d r2=%h want 4/4/1 585", g[0], g[1], g[2], r2);
      end
      tests++;
      if (mem_get_valid !== 1'b0 || dut.cnt[0] !== 3'd0
          || dut.cnt[1] !== 3'd0 || dut.cnt[2] !== 3'd0) begin
         fails++;
         $display("FAIL inflight_idle: mgv=%b cnt=%0d/%0d/%0d want 0 0/0/0", mem_get_valid, dut.cnt[0], dut.cnt[1], dut.cnt[2]);
      end
   endtask

   task automatic test_stall();
      mem_put_ready = 1'b0;
      get_en        = 1'b1;
      @(negedge CLK);
      set_put(1, 1'b1, 70'h700);
      @(negedge CLK);
      set_put(1, 1'b0, '0);
      set_put(0, 1'b1, 70'h600);
      tests++;
      if (mem_put_valid !== 1'b1 || mem_put_request !== 70'h700) begin
         fails++;
         $display("FAIL stall_c1: valid=%b req=%h want 1 700", mem_put_valid, mem_put_request);
      end
      @(negedge CLK);
      set_put(0, 1'b0, '0);
      tests++;
      if (mem_put_valid !== 1'b1 || mem_put_request !== 70'h700 || dut.grant !== 2'd1) begin
         fails++;
         $display("FAIL stall_c2: valid=%b req=%h grant=%0d want 1 700 1", mem_put_valid, mem_put_request, dut.grant);
      end
      @(negedge CLK);
      tests++;
      if (mem_put_valid !== 1'b1 || mem_put_request !== 70'h700 || dut.grant !== 2'd1) begin
         fails++;
         $display("FAIL stall_c3: valid=%b req=%h grant=%0d want 1 700 1", mem_put_valid, mem_put_request, dut.grant);
      end
      mem_put_ready = 1'b1;
      @(negedge CLK);
      tests++;
      if (mem_put_valid !== 1'b1 || mem_put_request !== 70'h600) begin
         fails++;
         $display("FAIL stall_next: valid=%b req=%h want 1 600", mem_put_valid, mem_put_request);
      end
      @(negedge CLK);
      tests++;
      if (mem_put_valid !== 1'b0) begin
         fails++;
         $display("FAIL stall_done: valid=%b want 0", mem_put_valid);
      end
      repeat (2) @(negedge CLK);
      tests++;
      if (gr(0) !== 1'b1 || gresp(0) !== 52'h62F
          || gr(1) !== 1'b1 || gresp(1) !== 52'h72F) begin
         fails++;
         $display("FAIL stall_resp: gr0=%b r0=%h gr1=%b r1=%h want 1 62f 1 72f", gr(0), gresp(0), gr(1), gresp(1));
      end
      set_get(0, 1'b1);
      set_get(1, 1'b1);
      @(negedge CLK);
      set_get(0, 1'b0);
      set_get(1, 1'b0);
      tests++;
      if (dut.cnt[0] !== 3'd0 || dut.cnt[1] !== 3'd0) begin
         fails++;
         $display("FAIL stall_cnt: cnt=%0d/%0d want 0/0", dut.cnt[0], dut.cnt[1]);
      end
   endtask

   initial begin
      tests         = 0;
      fails         = 0;
      put_fires     = 0;
      get_fires     = 0;
      q_ne          = 1'b0;
      q_head        = '0;
      get_en        = 1'b0;
      mem_put_ready = 1'b0;
      arg           = '0;
      RST           = 1'b1;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      test_reset();
      test_single();
      test_contention();
      test_credit();
      test_inflight();
      test_stall();
      repeat (2) @(negedge CLK);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
